// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with SP reset value, write bypass, optional read stage and pending-write scoreboard
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   regwrite, rd, wd  write port (rd == 0 is discarded)
//   ren               read capture enable, used only when READ_REG=1
//   rs1, rs2          read indices
//   rdata1, rdata2    read data (combinational or registered per READ_REG)
//   busy_set, busy_rd mark a register as waiting for an in-flight write
//   stall             a source register has an unresolved pending write
//   pend_vec          pending bit per register, bit 0 always 0
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int SP_IDX = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h0000_1000),
  parameter int READ_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regwrite,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  input  logic            ren,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_rd,
  output logic            stall,
  output logic [NREG-1:0] pend_vec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [XLEN-1:0] rv1, rv2;
  logic            wr_en;
  logic            haz1, haz2;

  assign wr_en = regwrite && (rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == SP_IDX && i != 0) ? SP_INIT : '0;
      end
    end else if (wr_en) begin
      regs[rd] <= wd;
    end
  end

  // A write in flight this cycle overrides the stale array contents.
  always_comb begin
    rv1 = (rs1 == '0) ? '0 : regs[rs1];
    rv2 = (rs2 == '0) ? '0 : regs[rs2];
    if (wr_en && rd == rs1) rv1 = wd;
    if (wr_en && rd == rs2) rv2 = wd;
  end

  // Set has priority over clear: a new producer issuing in the same cycle
  // as the old producer retiring leaves the register pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (busy_set && busy_rd == AW'(i)) begin
          pend[i] <= 1'b1;
        end else if (regwrite && rd == AW'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  assign pend_vec = pend;

  // A pending register being written this cycle is covered by the bypass.
  assign haz1  = pend[rs1] && !(regwrite && rd == rs1);
  assign haz2  = pend[rs2] && !(regwrite && rd == rs2);
  assign stall = haz1 || haz2;

  generate
    if (READ_REG != 0) begin : g_reg_read
      logic [XLEN-1:0] q1, q2;
      always_ff @(posedge clk) begin
        if (rst) begin
          q1 <= '0;
          q2 <= '0;
        end else if (ren) begin
          q1 <= rv1;
          q2 <= rv2;
        end
      end
      assign rdata1 = q1;
      assign rdata2 = q2;
    end else begin : g_comb_read
      logic unused_ren;
      assign unused_ren = ren;
      assign rdata1 = rv1;
      assign rdata2 = rv2;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb, combinational 32-bit and registered 64-bit builds
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst, regwrite, ren, busy_set;
  logic [4:0]  rd, rs1, rs2, busy_rd;
  logic [63:0] wd;

  logic [31:0] a_rdata1, a_rdata2, a_pend;
  logic        a_stall;
  logic [63:0] b_rdata1, b_rdata2;
  logic [15:0] b_pend;
  logic        b_stall;

  reg_file_sb u_a (
    .clk(clk), .rst(rst), .regwrite(regwrite), .rd(rd), .wd(wd[31:0]),
    .ren(ren), .rs1(rs1), .rs2(rs2), .rdata1(a_rdata1), .rdata2(a_rdata2),
    .busy_set(busy_set), .busy_rd(busy_rd), .stall(a_stall), .pend_vec(a_pend)
  );

  reg_file_sb #(
    .XLEN(64), .NREG(16), .AW(4), .SP_IDX(2), .SP_INIT(64'h8000), .READ_REG(1)
  ) u_b (
    .clk(clk), .rst(rst), .regwrite(regwrite), .rd(rd[3:0]), .wd(wd),
    .ren(ren), .rs1(rs1[3:0]), .rs2(rs2[3:0]), .rdata1(b_rdata1), .rdata2(b_rdata2),
    .busy_set(busy_set), .busy_rd(busy_rd[3:0]), .stall(b_stall), .pend_vec(b_pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] tag;
    logic         dut;
    logic [1:0]   sig;
    logic [63:0]  exp;
  } exp_t;

  exp_t q_now[$];
  exp_t q_reg[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input logic [127:0] tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %h expected %h", tag, got, exp);
    end
  endtask

  // sig: 0 rdata1, 1 rdata2, 2 stall, 3 pend_vec
  function automatic logic [63:0] observe(input logic d, input logic [1:0] s);
    logic [63:0] v;
    if (!d) begin
      case (s)
        2'd0:    v = {32'h0, a_rdata1};
        2'd1:    v = {32'h0, a_rdata2};
        2'd2:    v = {63'h0, a_stall};
        default: v = {32'h0, a_pend};
      endcase
    end else begin
      case (s)
        2'd0:    v = b_rdata1;
        2'd1:    v = b_rdata2;
        2'd2:    v = {63'h0, b_stall};
        default: v = {48'h0, b_pend};
      endcase
    end
    return v;
  endfunction

  task automatic exp_now(input logic [127:0] tag, input logic d, input logic [1:0] s, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.dut = d; e.sig = s; e.exp = v;
    q_now.push_back(e);
  endtask

  task automatic exp_reg(input logic [127:0] tag, input logic d, input logic [1:0] s, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.dut = d; e.sig = s; e.exp = v;
    q_reg.push_back(e);
  endtask

  task automatic exp_sb(input logic [127:0] tag, input logic st, input logic [63:0] pv);
    exp_now(tag, 1'b0, 2'd2, {63'h0, st});
    exp_now(tag, 1'b1, 2'd2, {63'h0, st});
    exp_now(tag, 1'b0, 2'd3, pv);
    exp_now(tag, 1'b1, 2'd3, pv);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    while (q_reg.size() > 0) begin
      e = q_reg.pop_front();
      check_eq(e.tag, observe(e.dut, e.sig), e.exp);
    end
  endtask

  task automatic settle();
    exp_t e;
    #1;
    while (q_now.size() > 0) begin
      e = q_now.pop_front();
      check_eq(e.tag, observe(e.dut, e.sig), e.exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; regwrite = 1'b0; rd = '0; wd = '0;
    ren = 1'b1; busy_set = 1'b0; busy_rd = '0;
  endtask

  initial begin
    idle();
    rs1 = '0; rs2 = '0;

    // reset with a write presented: write must be ignored
    tick(); rst = 1'b1; regwrite = 1'b1; rd = 5'd5; wd = 64'hDEAD; rs1 = 5'd2; rs2 = 5'd5;
    exp_reg("rst_q1", 1'b1, 2'd0, 64'h0);
    exp_reg("rst_q2", 1'b1, 2'd1, 64'h0);
    settle();

    tick(); idle(); rs1 = 5'd2; rs2 = 5'd5;
    exp_now("rst_sp", 1'b0, 2'd0, 64'h1000);
    exp_now("rst_r5", 1'b0, 2'd1, 64'h0);
    exp_sb("rst_sb", 1'b0, 64'h0);
    exp_reg("rst_sp_b", 1'b1, 2'd0, 64'h8000);
    exp_reg("rst_r5_b", 1'b1, 2'd1, 64'h0);
    settle();

    // write r7
    tick(); idle(); regwrite = 1'b1; rd = 5'd7; wd = 64'h1234_5678; rs1 = '0; rs2 = '0;
    exp_now("x0_rd", 1'b0, 2'd0, 64'h0);
    settle();

    // read r7, attempt write of x0
    tick(); idle(); regwrite = 1'b1; rd = 5'd0; wd = '1; rs1 = 5'd7; rs2 = 5'd0;
    exp_now("wr_r7", 1'b0, 2'd0, 64'h1234_5678);
    exp_now("x0_byp", 1'b0, 2'd1, 64'h0);
    exp_reg("wr_r7_b", 1'b1, 2'd0, 64'h1234_5678);
    exp_reg("x0_byp_b", 1'b1, 2'd1, 64'h0);
    settle();

    tick(); idle(); rs1 = '0; rs2 = '0;
    exp_now("x0_keep", 1'b0, 2'd1, 64'h0);
    settle();

    // bypass on both ports
    tick(); idle(); regwrite = 1'b1; rd = 5'd9; wd = 64'hA5A5_A5A5_A5A5_A5A5; rs1 = 5'd9; rs2 = 5'd9;
    exp_now("byp1", 1'b0, 2'd0, 64'hA5A5_A5A5);
    exp_now("byp2", 1'b0, 2'd1, 64'hA5A5_A5A5);
    exp_reg("byp1_b", 1'b1, 2'd0, 64'hA5A5_A5A5_A5A5_A5A5);
    exp_reg("byp2_b", 1'b1, 2'd1, 64'hA5A5_A5A5_A5A5_A5A5);
    settle();

    // ren=0: registered outputs hold across a write
    tick(); idle(); ren = 1'b0; regwrite = 1'b1; rd = 5'd9; wd = 64'h1111; rs1 = 5'd7; rs2 = 5'd9;
    exp_now("comb_r7", 1'b0, 2'd0, 64'h1234_5678);
    exp_now("comb_byp", 1'b0, 2'd1, 64'h1111);
    exp_reg("hold1", 1'b1, 2'd0, 64'hA5A5_A5A5_A5A5_A5A5);
    exp_reg("hold2", 1'b1, 2'd1, 64'hA5A5_A5A5_A5A5_A5A5);
    settle();

    tick(); idle(); rs1 = 5'd0; rs2 = 5'd9;
    exp_now("r9_new", 1'b0, 2'd1, 64'h1111);
    exp_reg("r9_new_b", 1'b1, 2'd1, 64'h1111);
    settle();

    // scoreboard: mark r4 pending
    tick(); idle(); busy_set = 1'b1; busy_rd = 5'd4; rs1 = '0; rs2 = '0;
    exp_sb("pre_set", 1'b0, 64'h0);
    settle();

    tick(); idle(); rs1 = 5'd4;
    exp_sb("haz_r4", 1'b1, 64'h10);
    settle();

    // retiring write: no stall, bypass supplies data
    tick(); idle(); regwrite = 1'b1; rd = 5'd4; wd = 64'h4444; rs1 = 5'd4;
    exp_sb("retire", 1'b0, 64'h10);
    exp_now("retire_d", 1'b0, 2'd0, 64'h4444);
    exp_reg("retire_b", 1'b1, 2'd0, 64'h4444);
    settle();

    tick(); idle(); rs1 = 5'd4;
    exp_sb("cleared", 1'b0, 64'h0);
    settle();

    // set/clear collision on r6
    tick(); idle(); busy_set = 1'b1; busy_rd = 5'd6; regwrite = 1'b1; rd = 5'd6; wd = 64'h55;
    rs1 = '0; rs2 = '0;
    settle();

    tick(); idle(); rs1 = 5'd6; rs2 = 5'd6;
    exp_sb("coll", 1'b1, 64'h40);
    exp_now("coll_d", 1'b0, 2'd0, 64'h55);
    exp_reg("coll_d_b", 1'b1, 2'd0, 64'h55);
    settle();

    // pend r3 and r8, then reset
    tick(); idle(); busy_set = 1'b1; busy_rd = 5'd3; rs1 = '0; rs2 = '0;
    settle();
    tick(); idle(); busy_set = 1'b1; busy_rd = 5'd8;
    exp_sb("pend3", 1'b0, 64'h48);
    settle();
    tick(); idle(); rs1 = 5'd3; rs2 = 5'd8;
    exp_sb("pend38", 1'b1, 64'h148);
    settle();

    tick(); idle(); rst = 1'b1; busy_set = 1'b1; busy_rd = 5'd5;
    settle();

    tick(); idle(); rs1 = 5'd2; rs2 = 5'd8;
    exp_sb("mid_rst", 1'b0, 64'h0);
    exp_now("mid_sp", 1'b0, 2'd0, 64'h1000);
    exp_reg("mid_sp_b", 1'b1, 2'd0, 64'h8000);
    settle();

    tick(); idle(); rs1 = 5'd7; rs2 = 5'd6;
    exp_now("wipe_r7", 1'b0, 2'd0, 64'h0);
    exp_now("wipe_r6", 1'b0, 2'd1, 64'h0);
    exp_reg("wipe_r7_b", 1'b1, 2'd0, 64'h0);
    settle();

    // busy_set on x0 does nothing
    tick(); idle(); busy_set = 1'b1; busy_rd = 5'd0; rs1 = '0; rs2 = '0;
    settle();
    tick(); idle();
    exp_sb("x0_busy", 1'b0, 64'h0);
    settle();

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the RV32I integer register file, for the multicycle core's decode/writeback path.
- Adds full synchronous reset of the array with a programmable stack-pointer init value, and write-to-read bypass.
- Adds an optional registered read stage and a per-register pending-write scoreboard that generates a hazard stall for the multicycle controller.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; must be a power of two, 2 to 32.
- AW, 5, register index width; must equal log2(NREG).
- SP_IDX, 2, index of the stack pointer register.
- SP_INIT, 32'h0000_1000, reset value of register SP_IDX.
- READ_REG, 0, 0 = combinational read ports; 1 = registered read ports with read enable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- regwrite  in  1  write enable
- rd  in  AW  write index
- wd  in  XLEN  write data
- ren  in  1  read enable; used only when READ_REG=1
- rs1  in  AW  read index, port 1
- rs2  in  AW  read index, port 2
- rdata1  out  XLEN  read data, port 1
- rdata2  out  XLEN  read data, port 2
- busy_set  in  1  mark register busy_rd as pending a write
- busy_rd  in  AW  index to mark pending
- stall  out  1  rs1 or rs2 has an unresolved pending write
- pend_vec  out  NREG  pending bit per register; bit 0 is always 0

Behaviour:
- Reset, sampled on a rising clk edge while rst=1:
  - all registers are cleared to 0, except register SP_IDX, which is loaded with SP_INIT;
  - all pend bits are cleared;
  - registered rdata1 and rdata2 are cleared to 0;
  - regwrite and busy_set are ignored in that cycle.
- Register 0 always reads 0 and is never written. Its pend bit is never set, and it never contributes to stall.
- Write: on an edge with regwrite=1, rd!=0 and rst=0, register rd takes wd. Writing SP_IDX is a normal write.
- Bypass (both READ_REG modes): if regwrite=1, rd!=0 and rd==rsN, then rdataN (READ_REG=0) or the captured value (READ_REG=1) is wd, not the stale array value.
- READ_REG=0: rdataN is a combinational function of rsN, the array and the bypass. Latency is 0.
- READ_REG=1:
  - on an edge with ren=1, rdataN captures the bypassed read value; latency is 1 cycle;
  - with ren=0, rdataN holds its value;
  - rdataN changes only on a clock edge.
- Scoreboard, per register i!=0:
  - an edge with busy_set=1 and busy_rd==i sets pend[i];
  - an edge with regwrite=1 and rd==i clears pend[i];
  - if both happen to the same i in one cycle, set wins (a new producer has issued) and the write data still lands;
  - busy_set with busy_rd=0 has no effect.
- Stall is combinational. For each N in {1,2}, hazN = pend[rsN] and not (regwrite=1 and rd==rsN); stall = haz1 or haz2.
  - A same-cycle write that retires a pending register therefore does not stall, because bypass supplies the data.
- Out-of-range indices cannot occur: AW is fixed to log2(NREG).
- Reset mid-operation wipes the array and the scoreboard; in-flight pending writes are forgotten.

Test Plan:
- Reset: assert rst for 1 cycle with regwrite=1, rd=5, wd=32'hDEAD. Required response:
  - rs1=2 gives rdata1=32'h0000_1000;
  - rs2=5 gives rdata2=0;
  - pend_vec=0.
- Write/read and x0:
  - write rd=7, wd=32'h1234_5678, then read rs1=7: rdata1=32'h1234_5678;
  - write rd=0, wd=32'hFFFF_FFFF: rs2=0 gives rdata2=0.
- Bypass:
  - same cycle regwrite=1, rd=9, wd=32'hA5A5_A5A5, rs1=rs2=9: both rdata equal 32'hA5A5_A5A5 before the edge (READ_REG=0), or after one edge with ren=1 (READ_REG=1);
  - READ_REG=1 with ren=0: rdata holds its previous value.
- Scoreboard stall:
  - busy_set with busy_rd=4, then rs1=4, regwrite=0: stall=1, pend_vec[4]=1;
  - next cycle regwrite=1, rd=4: stall=0 in that cycle, rdata1=wd, and pend_vec[4]=0 after the edge.
- Set/clear collision: same cycle busy_set with busy_rd=6 and regwrite=1, rd=6, wd=32'h55. Required response after the edge:
  - pend_vec[6]=1;
  - register 6 = 32'h55;
  - rs2=6 gives stall=1.
- Reset mid-pend: pend_vec[3] and pend_vec[8] set, then pulse rst. Required response:
  - pend_vec=0;
  - stall=0;
  - rs1=2 gives SP_INIT.
  Repeat with NREG=16, AW=4, XLEN=64, SP_INIT=64'h8000.
